cos_requester: RTL
==================

COS_REQUESTER -- requirements
Module: cos_requester

Interface
REQ-001 Parameter DEPTH, default 4: operand FIFO entries, power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 255: max WAIT cycles without eng_done, range 1..255.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  operand-push request.
REQ-006 in_x  in  16  angle operand, Q-format owned by the cosine engine, passed through unchanged.
REQ-007 in_y  in  8  term-count/precision operand, passed through unchanged.
REQ-008 in_ready  out  1  FIFO not full; a push occurs on an edge with in_valid=1 and in_ready=1.
REQ-009 eng_start  out  1  one-cycle start pulse to the cosine engine.
REQ-010 eng_x  out  16  operand x to the engine; held stable from the start pulse until the request completes.
REQ-011 eng_y  out  8  operand y to the engine; same hold rule as eng_x.
REQ-012 eng_done  in  1  engine completion strobe; only meaningful in WAIT.
REQ-013 eng_total  in  16  engine result; sampled on the edge eng_done is seen in WAIT.
REQ-014 out_valid  out  1  result available.
REQ-015 out_total  out  16  captured result.
REQ-016 out_err  out  1  current result is a timeout result.
REQ-017 out_ack  in  1  consumer accepts the result; transfer occurs on an edge with out_valid=1 and out_ack=1.
REQ-018 err_sticky  out  1  a timeout has occurred since reset.

Function
REQ-019 The operand FIFO SHALL hold {in_x,in_y} pairs, DEPTH entries, in first-in first-out order; in_ready = not full.
REQ-020 Pushes SHALL be refused while the FIFO is full; a push and a pop on the same edge SHALL both take effect.
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT, HOLD.
REQ-022 IDLE: if the FIFO is non-empty, pop the head into eng_x/eng_y and go to ISSUE on that edge; otherwise stay.
REQ-023 ISSUE: eng_start=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
REQ-024 WAIT: on eng_done=1, capture eng_total into out_total, set out_err=0, set out_valid=1, go to HOLD.
REQ-025 WAIT: without eng_done, increment the 8-bit timeout counter; when the counter equals TIMEOUT, set out_total=16'hFFFF, out_err=1, out_valid=1, err_sticky=1, and go to HOLD.
REQ-026 If eng_done arrives on the cycle the timeout would fire, eng_done SHALL win.
REQ-027 HOLD: out_valid stays 1 and out_total/out_err stay stable until out_ack=1; on that edge clear out_valid and go to IDLE.
REQ-028 eng_done outside WAIT SHALL be ignored, with no state change or capture.
REQ-029 Latency from empty IDLE: push at edge t; pop at t+1; eng_start high during cycle t+1..t+2; eng_done sampled at edge e gives out_valid=1 after e.
REQ-030 Only one engine request SHALL be outstanding at a time; eng_start is never asserted outside ISSUE.
REQ-031 out_ack while out_valid=0 SHALL have no effect.

Reset
REQ-032 On rst=1, asynchronously: state IDLE; FIFO empty (in_ready=1); eng_start=0; eng_x=0; eng_y=0; out_valid=0; out_total=0; out_err=0; err_sticky=0; timeout counter=0.
REQ-033 rst asserted mid-request (ISSUE/WAIT/HOLD) SHALL abandon the request and queued operands; a late eng_done after reset release SHALL be ignored per REQ-028.

Verification
REQ-034 Single op: push x=16'h1000, y=8'd5; engine returns done 10 cycles after start with total=16'h0D80 -> one eng_start pulse, eng_x=16'h1000 held, out_valid=1, out_total=16'h0D80, out_err=0, cleared by out_ack.
REQ-035 FIFO full: out_ack=0, engine stalled; push 4 operands plus the one in flight -> in_ready=0 after the 5th accepted push; later results appear in push order.
REQ-036 Timeout: TIMEOUT=8, engine never responds -> out_valid 9 cycles after eng_start falls, out_total=16'hFFFF, out_err=1, err_sticky=1; next operand issues after out_ack.
REQ-037 Done/timeout tie: eng_done on the timeout cycle -> out_err=0, out_total=eng_total, err_sticky unchanged.
REQ-038 Reset mid-WAIT with 2 queued operands -> all outputs at reset values immediately; a stray eng_done after release produces no out_valid.
REQ-039 Backpressure: hold out_ack=0 for 20 cycles in HOLD -> out_total stable, no new eng_start until ack.

Source files
------------

// File: rtl/cos_requester_if.sv
// Operand, engine and result signals of the cosine requester, grouped for port use.
// The requester itself sits on the slave side; the environment (producer/engine/consumer) on master.
interface cos_requester_if;
  logic        in_valid;
  logic [15:0] in_x;
  logic [7:0]  in_y;
  logic        in_ready;

  logic        eng_start;
  logic [15:0] eng_x;
  logic [7:0]  eng_y;
  logic        eng_done;
  logic [15:0] eng_total;

  logic        out_valid;
  logic [15:0] out_total;
  logic        out_err;
  logic        out_ack;
  logic        err_sticky;

  modport slave (
    input  in_valid, in_x, in_y, eng_done, eng_total, out_ack,
    output in_ready, eng_start, eng_x, eng_y, out_valid, out_total, out_err, err_sticky
  );

  modport master (
    output in_valid, in_x, in_y, eng_done, eng_total, out_ack,
    input  in_ready, eng_start, eng_x, eng_y, out_valid, out_total, out_err, err_sticky
  );
endinterface

// File: rtl/cos_requester.sv
// Queues {x,y} operands and issues them one at a time to a cosine engine,
// with a per-request timeout and a held result until the consumer acknowledges.
module cos_requester #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  cos_requester_if.slave bus
);
  localparam int          AW  = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);
  localparam logic [7:0]  TO  = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [AW:0] wptr_q, rptr_q;
  logic [23:0] mem_q [DEPTH];
  logic [15:0] eng_x_q, eng_x_d;
  logic [7:0]  eng_y_q, eng_y_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_total_q, out_total_d;
  logic        out_err_q, out_err_d;
  logic        sticky_q, sticky_d;

  logic full, empty, push, pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push  = bus.in_valid && !full;
  assign pop   = (state_q == IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {bus.in_x, bus.in_y};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + ONE;
      if (pop)  rptr_q <= rptr_q + ONE;
    end
  end

  always_comb begin
    state_d     = state_q;
    eng_x_d     = eng_x_q;
    eng_y_d     = eng_y_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_total_d = out_total_q;
    out_err_d   = out_err_q;
    sticky_d    = sticky_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          {eng_x_d, eng_y_d} = mem_q[rptr_q[AW-1:0]];
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion on the timeout cycle takes priority over the timeout.
        if (bus.eng_done) begin
          out_total_d = bus.eng_total;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (cnt_q == TO) begin
          out_total_d = 16'hFFFF;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          sticky_d    = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (bus.out_ack) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      eng_x_q     <= '0;
      eng_y_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_total_q <= '0;
      out_err_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      eng_x_q     <= eng_x_d;
      eng_y_q     <= eng_y_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_total_q <= out_total_d;
      out_err_q   <= out_err_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.in_ready   = !full;
  assign bus.eng_start  = (state_q == ISSUE);
  assign bus.eng_x      = eng_x_q;
  assign bus.eng_y      = eng_y_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_total  = out_total_q;
  assign bus.out_err    = out_err_q;
  assign bus.err_sticky = sticky_q;
endmodule
